// File: rtl/cpu_types_pkg.sv
// Shared CPU types: bus word, RAM handshake state and RAM responder defaults.
package cpu_types_pkg;

  localparam int unsigned WORD_W          = 32;
  localparam int unsigned RAM_CNT_W       = 4;
  localparam int unsigned RAM_LAT_DEFAULT = 2;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/ram_responder_if.sv
// RAM request/response bus between a requester (master) and the RAM responder (slave).
interface ram_responder_if;
  import cpu_types_pkg::*;

  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport master (
    output ramREN, ramWEN, ramaddr, ramstore,
    input  ramload, ramstate
  );

  modport slave (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );

endinterface

// File: rtl/ram_responder_array.sv
// Word storage for the RAM responder: one synchronous write port, one async read port.
// Contents are deliberately not reset.
module ram_array
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     CLK,
  input  logic                     wen,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  word_t                    wdata,
  output word_t                    rdata
);

  word_t mem_q [DEPTH];

  always_ff @(posedge CLK) begin
    if (wen) mem_q[idx] <= wdata;
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/ram_responder.sv
// Latency-modelling RAM responder: FREE -> BUSY x LAT -> ACCESS -> FREE, with ERROR on protocol abuse.
// Define RAM_ALIGN_CHECK_EN to reject requests whose byte address is not word aligned.
module ram_responder
  import cpu_types_pkg::*;
#(
  parameter int unsigned LAT   = RAM_LAT_DEFAULT,
  parameter int unsigned DEPTH = 1024
) (
  input  logic            CLK,
  input  logic            nRST,
  ram_responder_if.slave  ram
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  ramstate_t              state_q, state_d;
  logic [RAM_CNT_W-1:0]   cnt_q, cnt_d;
  word_t                  addr_q, addr_d;
  logic                   is_wr_q, is_wr_d;

  logic                   both_c, req_c, misalign_c;
  logic                   wen_c, rd_c;
  word_t                  rdata_c;

  assign both_c = ram.ramREN & ram.ramWEN;
  assign req_c  = ram.ramREN ^ ram.ramWEN;

`ifdef RAM_ALIGN_CHECK_EN
  assign misalign_c = (ram.ramaddr[1:0] != 2'b00);
`else
  assign misalign_c = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= FREE;
      cnt_q   <= '0;
      addr_q  <= '0;
      is_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      is_wr_q <= is_wr_d;
    end
  end

  // Next state; the request is only captured in FREE and must stay stable while BUSY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    is_wr_d = is_wr_q;
    unique case (state_q)
      FREE: begin
        if (both_c) begin
          state_d = ERROR;
        end else if (req_c) begin
          if (misalign_c) begin
            state_d = ERROR;
          end else begin
            addr_d  = ram.ramaddr;
            is_wr_d = ram.ramWEN;
            cnt_d   = RAM_CNT_W'(LAT);
            state_d = (LAT > 0) ? BUSY : ACCESS;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - RAM_CNT_W'(1);
        if (both_c)                       state_d = ERROR;
        else if (!req_c)                  state_d = FREE;
        else if (ram.ramaddr != addr_q)   state_d = ERROR;
        else if (cnt_q == RAM_CNT_W'(1))  state_d = ACCESS;
      end
      ACCESS:  state_d = FREE;
      ERROR:   state_d = FREE;
      default: state_d = FREE;
    endcase
  end

  assign wen_c = (state_q == ACCESS) &&  is_wr_q;
  assign rd_c  = (state_q == ACCESS) && !is_wr_q;

  ram_array #(.DEPTH(DEPTH)) u_array (
    .CLK   (CLK),
    .wen   (wen_c),
    .idx   (addr_q[IDX_W+1:2]),
    .wdata (ram.ramstore),
    .rdata (rdata_c)
  );

  assign ram.ramload  = rd_c ? rdata_c : '0;
  assign ram.ramstate = state_q;

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: LAT=2/DEPTH=1024 and LAT=0/DEPTH=16 instances.
module tb_ram_responder;
  import cpu_types_pkg::*;

  logic CLK;
  logic nRST;

  ram_responder_if m0();
  ram_responder_if m1();

  ram_responder #(.LAT(2), .DEPTH(1024)) u_dut0 (.CLK(CLK), .nRST(nRST), .ram(m0));
  ram_responder #(.LAT(0), .DEPTH(16))   u_dut1 (.CLK(CLK), .nRST(nRST), .ram(m1));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit        sel;
    logic      ren;
    logic      wen;
    word_t     addr;
    word_t     store;
    ramstate_t exp_st;
    word_t     exp_ld;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void add(bit s, logic r, logic w, word_t a, word_t d,
                              ramstate_t st, word_t ld);
    vec_t v;
    v.sel = s; v.ren = r; v.wen = w; v.addr = a; v.store = d;
    v.exp_st = st; v.exp_ld = ld;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input word_t act, input word_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_out(input bit s, input int idx, input ramstate_t st, input word_t ld);
    if (s == 1'b0) begin
      check("state0", idx, 32'(m0.ramstate), 32'(st));
      check("load0",  idx, m0.ramload, ld);
    end else begin
      check("state1", idx, 32'(m1.ramstate), 32'(st));
      check("load1",  idx, m1.ramload, ld);
    end
  endtask

  task automatic drive(input bit s, input logic r, input logic w, input word_t a, input word_t d);
    if (s == 1'b0) begin
      m0.ramREN = r; m0.ramWEN = w; m0.ramaddr = a; m0.ramstore = d;
      m1.ramREN = 1'b0; m1.ramWEN = 1'b0;
    end else begin
      m1.ramREN = r; m1.ramWEN = w; m1.ramaddr = a; m1.ramstore = d;
      m0.ramREN = 1'b0; m0.ramWEN = 1'b0;
    end
  endtask

  task automatic step(input bit s, input logic r, input logic w, input word_t a, input word_t d);
    drive(s, r, w, a, d);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    m0.ramREN = 1'b0; m0.ramWEN = 1'b0; m0.ramaddr = '0; m0.ramstore = '0;
    m1.ramREN = 1'b0; m1.ramWEN = 1'b0; m1.ramaddr = '0; m1.ramstore = '0;
    nRST = 1'b0;

    // LAT=2: write DEADBEEF to 0x40, then read it back
    add(0, 0, 1, 32'h40, 32'hDEADBEEF, BUSY,   32'h0);
    add(0, 0, 1, 32'h40, 32'hDEADBEEF, BUSY,   32'h0);
    add(0, 0, 1, 32'h40, 32'hDEADBEEF, ACCESS, 32'h0);
    add(0, 0, 0, 32'h40, 32'hDEADBEEF, FREE,   32'h0);
    add(0, 1, 0, 32'h40, 32'h0,        BUSY,   32'h0);
    add(0, 1, 0, 32'h40, 32'h0,        BUSY,   32'h0);
    add(0, 1, 0, 32'h40, 32'h0,        ACCESS, 32'hDEADBEEF);
    add(0, 0, 0, 32'h40, 32'h0,        FREE,   32'h0);
    // both requests in FREE -> ERROR, array untouched
    add(0, 1, 1, 32'h40, 32'h0BAD0BAD, ERROR,  32'h0);
    add(0, 0, 0, 32'h40, 32'h0,        FREE,   32'h0);
    add(0, 1, 0, 32'h40, 32'h0,        BUSY,   32'h0);
    add(0, 1, 0, 32'h40, 32'h0,        BUSY,   32'h0);
    add(0, 1, 0, 32'h40, 32'h0,        ACCESS, 32'hDEADBEEF);
    add(0, 0, 0, 32'h40, 32'h0,        FREE,   32'h0);
    // prime 0x44, then abort a write by changing address in BUSY
    add(0, 0, 1, 32'h44, 32'h11111111, BUSY,   32'h0);
    add(0, 0, 1, 32'h44, 32'h11111111, BUSY,   32'h0);
    add(0, 0, 1, 32'h44, 32'h11111111, ACCESS, 32'h0);
    add(0, 0, 0, 32'h44, 32'h11111111, FREE,   32'h0);
    add(0, 0, 1, 32'h40, 32'hCAFEF00D, BUSY,   32'h0);
    add(0, 0, 1, 32'h44, 32'hCAFEF00D, ERROR,  32'h0);
    add(0, 0, 0, 32'h44, 32'hCAFEF00D, FREE,   32'h0);
    add(0, 1, 0, 32'h44, 32'h0,        BUSY,   32'h0);
    add(0, 1, 0, 32'h44, 32'h0,        BUSY,   32'h0);
    add(0, 1, 0, 32'h44, 32'h0,        ACCESS, 32'h11111111);
    add(0, 0, 0, 32'h44, 32'h0,        FREE,   32'h0);
    add(0, 1, 0, 32'h40, 32'h0,        BUSY,   32'h0);
    add(0, 1, 0, 32'h40, 32'h0,        BUSY,   32'h0);
    add(0, 1, 0, 32'h40, 32'h0,        ACCESS, 32'hDEADBEEF);
    add(0, 0, 0, 32'h40, 32'h0,        FREE,   32'h0);
    // write dropped in BUSY, then both requests raised in BUSY
    add(0, 0, 1, 32'h40, 32'h0,        BUSY,   32'h0);
    add(0, 0, 0, 32'h40, 32'h0,        FREE,   32'h0);
    add(0, 1, 0, 32'h40, 32'h0,        BUSY,   32'h0);
    add(0, 1, 1, 32'h40, 32'h0,        ERROR,  32'h0);
    add(0, 0, 0, 32'h40, 32'h0,        FREE,   32'h0);
    // upper address bits ignored
    add(0, 1, 0, 32'h80000040, 32'h0,  BUSY,   32'h0);
    add(0, 1, 0, 32'h80000040, 32'h0,  BUSY,   32'h0);
    add(0, 1, 0, 32'h80000040, 32'h0,  ACCESS, 32'hDEADBEEF);
    add(0, 0, 0, 32'h80000040, 32'h0,  FREE,   32'h0);
    // LAT=0, DEPTH=16: ACCESS on first edge, index wraps (0x40 -> word 0)
    add(1, 0, 1, 32'h0,  32'h12345678, ACCESS, 32'h0);
    add(1, 0, 0, 32'h0,  32'h12345678, FREE,   32'h0);
    add(1, 1, 0, 32'h0,  32'h0,        ACCESS, 32'h12345678);
    add(1, 0, 0, 32'h0,  32'h0,        FREE,   32'h0);
    add(1, 1, 0, 32'h40, 32'h0,        ACCESS, 32'h12345678);
    add(1, 0, 0, 32'h40, 32'h0,        FREE,   32'h0);
    add(1, 1, 1, 32'h0,  32'h0,        ERROR,  32'h0);
    add(1, 0, 0, 32'h0,  32'h0,        FREE,   32'h0);

    #12;
    check_out(0, -1, FREE, 32'h0);
    check_out(1, -1, FREE, 32'h0);
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    foreach (vecs[i]) begin
      step(vecs[i].sel, vecs[i].ren, vecs[i].wen, vecs[i].addr, vecs[i].store);
      check_out(vecs[i].sel, i, vecs[i].exp_st, vecs[i].exp_ld);
    end

    // reset mid-BUSY on a write: immediate FREE, target word unchanged
    step(0, 0, 1, 32'h40, 32'h55555555);
    check_out(0, 100, BUSY, 32'h0);
    #2 nRST = 1'b0;
    #1 check_out(0, 101, FREE, 32'h0);
    drive(0, 0, 0, 32'h40, 32'h0);
    #1 nRST = 1'b1;
    step(0, 1, 0, 32'h40, 32'h0);
    check_out(0, 102, BUSY, 32'h0);
    step(0, 1, 0, 32'h40, 32'h0);
    check_out(0, 103, BUSY, 32'h0);
    step(0, 1, 0, 32'h40, 32'h0);
    check_out(0, 104, ACCESS, 32'hDEADBEEF);
    step(0, 0, 0, 32'h40, 32'h0);
    check_out(0, 105, FREE, 32'h0);

    // misaligned read of 0x41
`ifdef RAM_ALIGN_CHECK_EN
    step(0, 1, 0, 32'h41, 32'h0);
    check_out(0, 110, ERROR, 32'h0);
    step(0, 0, 0, 32'h41, 32'h0);
    check_out(0, 111, FREE, 32'h0);
`else
    step(0, 1, 0, 32'h41, 32'h0);
    check_out(0, 110, BUSY, 32'h0);
    step(0, 1, 0, 32'h41, 32'h0);
    check_out(0, 111, BUSY, 32'h0);
    step(0, 1, 0, 32'h41, 32'h0);
    check_out(0, 112, ACCESS, 32'hDEADBEEF);
    step(0, 0, 0, 32'h41, 32'h0);
    check_out(0, 113, FREE, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 SHALL have parameter LAT, default 2, meaning the number of BUSY cycles per access (range 0..15).
REQ-002 SHALL have parameter DEPTH, default 1024, meaning storage size in 32-bit words (power of 2).
REQ-003 SHALL have port CLK, input, 1 bit, the clock; all state updates on the rising edge.
REQ-004 SHALL have port nRST, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port ramREN, input, 1 bit, read request, held until ACCESS.
REQ-006 SHALL have port ramWEN, input, 1 bit, write request, held until ACCESS.
REQ-007 SHALL have port ramaddr, input, 32 bits (word_t), byte address; word index = ramaddr[log2(DEPTH)+1:2].
REQ-008 SHALL have port ramstore, input, 32 bits, write data.
REQ-009 SHALL have port ramload, output, 32 bits, read data.
REQ-010 SHALL have port ramstate, output, ramstate_t (FREE, BUSY, ACCESS, ERROR), registered access status.

Function
REQ-011 FSM states SHALL be FREE, BUSY, ACCESS, ERROR; ramstate SHALL equal the current state.
REQ-012 In FREE, a request (ramREN xor ramWEN) SHALL capture ramaddr and the request type, and load counter = LAT; next state BUSY if LAT>0, else ACCESS.
REQ-013 In BUSY, the counter SHALL decrement each cycle; at counter==1 next state SHALL be ACCESS; request-to-ACCESS latency is exactly LAT+1 edges.
REQ-014 ACCESS SHALL last exactly one cycle, then FREE unconditionally; a new request is sampled only in FREE.
REQ-015 During ACCESS with a captured read, ramload SHALL be combinationally array[captured index]; otherwise ramload SHALL be 0.
REQ-016 A captured write SHALL commit ramstore to array[captured index] on the edge ending ACCESS, sampling ramstore in that cycle.
REQ-017 ramREN and ramWEN both high in FREE or BUSY SHALL produce next state ERROR.
REQ-018 ramaddr differing from the captured address during BUSY SHALL produce next state ERROR.
REQ-019 Both requests dropping during BUSY SHALL return to FREE with no write.
REQ-020 ERROR SHALL last one cycle, then FREE; no array write occurs for an aborted transaction.
REQ-021 Word index SHALL wrap modulo DEPTH; upper address bits SHALL be ignored.

Reset
REQ-022 nRST low SHALL force state FREE, counter 0, captured address 0, ramload 0, and ramstate FREE, asynchronously.
REQ-023 Array contents SHALL NOT be reset; reset mid-transaction SHALL abort it with no write.

Configuration
REQ-024 With RAM_ALIGN_CHECK_EN defined, a request in FREE with ramaddr[1:0] != 0 SHALL go to ERROR.
REQ-025 Without RAM_ALIGN_CHECK_EN, ramaddr[1:0] SHALL be ignored.

Structure
REQ-026 ramstate_t and word_t SHALL come from cpu_types_pkg; the LAT default constant (RAM_LAT_DEFAULT) SHALL be added to that package.
REQ-027 Storage SHALL be a sub-module ram_array (1 write port, 1 async read port); FSM and counter SHALL live in ram_responder.

Verification
REQ-028 LAT=2, write 0xDEADBEEF to 0x40: states FREE,BUSY,BUSY,ACCESS,FREE; then a read of 0x40 SHALL give ramload 0xDEADBEEF during ACCESS.
REQ-029 LAT=0, read 0x0 after writing 0x12345678: ACCESS SHALL occur on the first edge after the request.
REQ-030 ramREN=ramWEN=1 in FREE -> ERROR for one cycle, then FREE; array unchanged.
REQ-031 Address 0x40 changed to 0x44 in BUSY -> ERROR; a later read of 0x44 SHALL return its prior value.
REQ-032 nRST pulsed low mid-BUSY on a write -> FREE immediately, and the target word SHALL be unchanged.
REQ-033 With RAM_ALIGN_CHECK_EN defined, a read of 0x41 -> ERROR; without it, the read returns word 0x40.
